// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared state encoding, widths and reset constants for the 7-segment scan sequencer
package seg_scan_pkg;

  localparam int SCAN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_e;

  localparam logic [31:0] HEXS_RST  = 32'h0000_0000;
  localparam logic [7:0]  POINT_RST = 8'h00;
  localparam logic [7:0]  LES_RST   = 8'h00;

  // Wraps to digit 0 after the last scanned digit.
  function automatic logic [SCAN_W-1:0] next_digit(input logic [SCAN_W-1:0] cur,
                                                   input logic [SCAN_W-1:0] last);
    return (cur == last) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// rtl/seg_scan_prescaler.sv - modulo-(DIV_MAX+1) counter with clear/enable and terminal-count pulse
module seg_scan_prescaler
  import seg_scan_pkg::*;
#(
  parameter int DIV_MAX = 49999,
  parameter int DIV_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_MAX);

  logic [DIV_W-1:0] cnt;

  // Clear wins over enable, so a cleared counter never reports terminal count.
  assign tc = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - scan sequencer with blank gaps and frame-boundary double buffering
// Optional PWM dimming (duty input) when SEG_SCAN_DIMMING_EN is defined.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIV_MAX   = 49999,
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 16,
  parameter int DIGITS    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       hexs_in,
  input  logic [7:0]        point_in,
  input  logic [7:0]        les_in,
`ifdef SEG_SCAN_DIMMING_EN
  input  logic [3:0]        duty,
`endif
  output logic [SCAN_W-1:0] Scan,
  output logic [31:0]       Hexs,
  output logic [7:0]        point,
  output logic [7:0]        LES,
  output logic              blank,
  output logic              frame_done
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_SHOW = 2'(ST_SHOW);
  localparam logic [1:0] S_GAP  = 2'(ST_GAP);

  localparam logic [SCAN_W-1:0] LAST_DIGIT = SCAN_W'(DIGITS - 1);

  logic [1:0]  state, state_nxt;
  logic        show_tc, gap_tc;
  logic        advance, wrap, take, commit;
  logic        show_blank;
  logic [31:0] stg_hexs;
  logic [7:0]  stg_point, stg_les;

  seg_scan_prescaler #(
    .DIV_MAX (DIV_MAX),
    .DIV_W   (DIV_W)
  ) u_show_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!en || (state != S_SHOW)),
    .en  (state == S_SHOW),
    .tc  (show_tc)
  );

  seg_scan_prescaler #(
    .DIV_MAX (BLANK_CYC - 1),
    .DIV_W   (8)
  ) u_gap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!en || (state != S_GAP)),
    .en  (state == S_GAP),
    .tc  (gap_tc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (en) state_nxt = S_SHOW;
      S_SHOW: begin
        if (!en)          state_nxt = S_IDLE;
        else if (show_tc) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (!en)         state_nxt = S_IDLE;
        else if (gap_tc) state_nxt = S_SHOW;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign advance = en && (state == S_GAP) && gap_tc;
  assign wrap    = advance && (Scan == LAST_DIGIT);
  assign take    = ld_valid && ld_ready;
  // Staging is full exactly when ld_ready is low; outside an active scan it drains immediately.
  assign commit  = !ld_ready && (wrap || !en || (state == S_IDLE));

`ifdef SEG_SCAN_DIMMING_EN
  logic [3:0] pwm_cnt, pwm_nxt;

  assign pwm_nxt    = (state == S_SHOW) ? pwm_cnt + 4'd1 : 4'd0;
  assign show_blank = (pwm_nxt >= duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= (state_nxt == S_SHOW) ? pwm_nxt : 4'd0;
    end
  end
`else
  assign show_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      Scan       <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      ld_ready   <= 1'b1;
      Hexs       <= HEXS_RST;
      point      <= POINT_RST;
      LES        <= LES_RST;
      stg_hexs   <= HEXS_RST;
      stg_point  <= POINT_RST;
      stg_les    <= LES_RST;
    end else begin
      state      <= state_nxt;
      blank      <= (state_nxt == S_SHOW) ? show_blank : 1'b1;
      frame_done <= wrap;

      if (state_nxt == S_IDLE) begin
        Scan <= '0;
      end else if (advance) begin
        Scan <= next_digit(Scan, LAST_DIGIT);
      end

      if (take) begin
        stg_hexs  <= hexs_in;
        stg_point <= point_in;
        stg_les   <= les_in;
        ld_ready  <= 1'b0;
      end else if (commit) begin
        Hexs     <= stg_hexs;
        point    <= stg_point;
        LES      <= stg_les;
        ld_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (table, directed and randomized phases)
module tb_seg_scan_ctrl;

  localparam int DM    = 3;
  localparam int BC    = 2;
  localparam int DG    = 4;
  localparam int P     = DM + 1 + BC;
  localparam int FRAME = P * DG;

  logic        clk = 1'b0;
  logic        rst, en, ld_valid, ld_ready, blank, frame_done;
  logic [31:0] hexs_in, Hexs;
  logic [7:0]  point_in, les_in, point, LES;
  logic [2:0]  Scan;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef SEG_SCAN_DIMMING_EN
  logic [3:0] duty_main = 4'hF;
  logic [3:0] duty_d;
  logic       en_d, ld_ready_d, blank_d, fd_d;
  logic [2:0] scan_d;
  logic [31:0] hexs_d;
  logic [7:0]  point_d, les_d;
`endif

  seg_scan_ctrl #(.DIV_MAX(DM), .DIV_W(16), .BLANK_CYC(BC), .DIGITS(DG)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .hexs_in    (hexs_in),
    .point_in   (point_in),
    .les_in     (les_in),
`ifdef SEG_SCAN_DIMMING_EN
    .duty       (duty_main),
`endif
    .Scan       (Scan),
    .Hexs       (Hexs),
    .point      (point),
    .LES        (LES),
    .blank      (blank),
    .frame_done (frame_done)
  );

`ifdef SEG_SCAN_DIMMING_EN
  seg_scan_ctrl #(.DIV_MAX(15), .DIV_W(16), .BLANK_CYC(BC), .DIGITS(DG)) dut_dim (
    .clk        (clk),
    .rst        (rst),
    .en         (en_d),
    .ld_valid   (1'b0),
    .ld_ready   (ld_ready_d),
    .hexs_in    (32'h0),
    .point_in   (8'h0),
    .les_in     (8'h0),
    .duty       (duty_d),
    .Scan       (scan_d),
    .Hexs       (hexs_d),
    .point      (point_d),
    .LES        (les_d),
    .blank      (blank_d),
    .frame_done (fd_d)
  );
`endif

  // Reference model: time-since-enable view of the scan plus a one-entry staging buffer.
  bit          m_run  = 1'b0;
  int          m_t    = 0;
  bit          m_pend = 1'b0;
  bit          m_fd   = 1'b0;
  logic [31:0] m_hexs = 32'h0, s_hexs = 32'h0;
  logic [7:0]  m_point = 8'h0, m_les = 8'h0, s_point = 8'h0, s_les = 8'h0;

  typedef struct {
    int         t;
    logic [2:0] scan;
    logic       blank;
    logic       fd;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m_scan",  32'(Scan),       m_run ? 32'((m_t / P) % DG) : 32'd0);
    check("m_blank", 32'(blank),      m_run ? 32'((m_t % P) > DM) : 32'd1);
    check("m_fd",    32'(frame_done), 32'(m_fd));
    check("m_ready", 32'(ld_ready),   32'(!m_pend));
    check("m_hexs",  Hexs,            m_hexs);
    check("m_point", 32'(point),      32'(m_point));
    check("m_les",   32'(LES),        32'(m_les));
  endtask

  task automatic step();
    bit was_run, old_pend, wrap;
    was_run  = m_run;
    old_pend = m_pend;
    if (rst) begin
      m_run = 0; m_t = 0; m_pend = 0; m_fd = 0;
      m_hexs = 32'h0; m_point = 8'h0; m_les = 8'h0;
    end else begin
      if (!en) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0;
      end else begin
        m_t++;
      end
      wrap = m_run && was_run && (m_t % FRAME == 0);
      m_fd = wrap;
      if (old_pend && (wrap || !en || !was_run)) begin
        m_hexs = s_hexs; m_point = s_point; m_les = s_les; m_pend = 0;
      end else if (!old_pend && ld_valid) begin
        s_hexs = hexs_in; s_point = point_in; s_les = les_in; m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic wait_scan(input string name, input logic [2:0] s, input logic b);
    for (int i = 0; i < 200; i++) begin
      if (Scan == s && blank == b) return;
      step();
    end
    checks++; errors++;
    $display("FAIL %s: timeout waiting for Scan=%0d blank=%0d", name, s, b);
  endtask

  task automatic wait_fd(input string name);
    for (int i = 0; i < 200; i++) begin
      if (frame_done) return;
      step();
    end
    checks++; errors++;
    $display("FAIL %s: timeout waiting for frame_done", name);
  endtask

  initial begin
    int n;
    vecs[0]  = '{0,  3'd0, 1'b0, 1'b0};
    vecs[1]  = '{3,  3'd0, 1'b0, 1'b0};
    vecs[2]  = '{4,  3'd0, 1'b1, 1'b0};
    vecs[3]  = '{5,  3'd0, 1'b1, 1'b0};
    vecs[4]  = '{6,  3'd1, 1'b0, 1'b0};
    vecs[5]  = '{11, 3'd1, 1'b1, 1'b0};
    vecs[6]  = '{12, 3'd2, 1'b0, 1'b0};
    vecs[7]  = '{18, 3'd3, 1'b0, 1'b0};
    vecs[8]  = '{23, 3'd3, 1'b1, 1'b0};
    vecs[9]  = '{24, 3'd0, 1'b0, 1'b1};
    vecs[10] = '{25, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{48, 3'd0, 1'b0, 1'b1};

    rst = 1; en = 0; ld_valid = 0; hexs_in = 0; point_in = 0; les_in = 0;
`ifdef SEG_SCAN_DIMMING_EN
    en_d = 0; duty_d = 4'd0;
`endif
    step(); step();
    check("rst_scan",  32'(Scan), 32'd0);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_fd",    32'(frame_done), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd1);
    check("rst_hexs",  Hexs, 32'd0);
    check("rst_point", 32'(point), 32'd0);
    check("rst_les",   32'(LES), 32'd0);

    rst = 0; step();
    en = 1; step();
    n = 0;
    for (int v = 0; v < 12; v++) begin
      while (n < vecs[v].t) begin step(); n++; end
      check($sformatf("tbl_scan_t%0d", vecs[v].t),  32'(Scan),       32'(vecs[v].scan));
      check($sformatf("tbl_blank_t%0d", vecs[v].t), 32'(blank),      32'(vecs[v].blank));
      check($sformatf("tbl_fd_t%0d", vecs[v].t),    32'(frame_done), 32'(vecs[v].fd));
    end

    // Load mid-frame, then a held second request while staging is full.
    wait_scan("ld_wait_s1", 3'd1, 1'b0);
    ld_valid = 1; hexs_in = 32'h1234_5678; step();
    check("ld_ready_low", 32'(ld_ready), 32'd0);
    check("ld_hexs_old",  Hexs, 32'd0);
    hexs_in = 32'hDEAD_BEEF; step();
    check("ld_ignored", Hexs, 32'd0);
    wait_fd("ld_wrap1");
    check("ld_commit1", Hexs, 32'h1234_5678);
    check("ld_ready_back", 32'(ld_ready), 32'd1);
    step();
    check("ld_held_taken", 32'(ld_ready), 32'd0);
    check("ld_hexs_keep",  Hexs, 32'h1234_5678);
    ld_valid = 0;
    wait_fd("ld_wrap2");
    check("ld_commit2", Hexs, 32'hDEAD_BEEF);

    // Disable mid-SHOW, then load while disabled.
    wait_scan("dis_wait_s2", 3'd2, 1'b0);
    en = 0; step();
    check("dis_scan",  32'(Scan), 32'd0);
    check("dis_blank", 32'(blank), 32'd1);
    check("dis_fd",    32'(frame_done), 32'd0);
    ld_valid = 1; point_in = 8'hA5; step();
    ld_valid = 0;
    check("idle_point_old", 32'(point), 32'd0);
    step();
    check("idle_point_new", 32'(point), 32'hA5);
    check("idle_ready",     32'(ld_ready), 32'd1);

    // Reset during GAP with staging full discards the staged data.
    en = 1; ld_valid = 1; hexs_in = 32'hCAFE_F00D; step();
    ld_valid = 0;
    check("gap_staged", 32'(ld_ready), 32'd0);
    wait_scan("gap_wait", 3'd0, 1'b1);
    rst = 1; step();
    check("gap_rst_scan",  32'(Scan), 32'd0);
    check("gap_rst_blank", 32'(blank), 32'd1);
    check("gap_rst_ready", 32'(ld_ready), 32'd1);
    check("gap_rst_hexs",  Hexs, 32'd0);
    check("gap_rst_point", 32'(point), 32'd0);
    rst = 0; en = 0; step(); step();
    check("gap_no_commit", Hexs, 32'd0);

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      en       = ($urandom_range(0, 99) < 97);
      ld_valid = ($urandom_range(0, 9) < 3);
      hexs_in  = $urandom;
      point_in = 8'($urandom);
      les_in   = 8'($urandom);
      step();
    end
    rst = 0; en = 0; ld_valid = 0;

`ifdef SEG_SCAN_DIMMING_EN
    begin
      int lit;
      rst = 1; step(); rst = 0;
      duty_d = 4'd2; en_d = 1; step();
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        if (!blank_d) lit++;
        step();
      end
      check("dim_lit_duty2", 32'(lit), 32'd2);
      check("dim_gap_blank", 32'(blank_d), 32'd1);
      step(); step();
      check("dim_scan1", 32'(scan_d), 32'd1);
      en_d = 0; duty_d = 4'd0; step();
      en_d = 1; step();
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        if (!blank_d) lit++;
        step();
      end
      check("dim_lit_duty0", 32'(lit), 32'd0);
      step(); step();
      check("dim_scan1_dark", 32'(scan_d), 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequencer for the 7-segment scan multiplexer.
- Generates the 3-bit digit index `Scan` from a clock prescaler and inserts anti-ghosting blank gaps between digits.
- Double-buffers display data (`Hexs`/`point`/`LES`). New data enters through a valid/ready handshake and commits only at frame boundaries, so a frame never shows a mix of old and new data.
- Sits between the CPU/IO register and the scan mux. `blank` gates the digit-enable outputs downstream.

Parameters:
- DIV_MAX, 49999, SHOW-state cycles per digit minus 1 (100 MHz → 2 kHz per digit)
- DIV_W, 16, prescaler width; must satisfy DIV_W ≥ clog2(DIV_MAX+1)
- BLANK_CYC, 16, blank-gap length in cycles between digits; 1..255
- DIGITS, 4, number of scanned digits; 1..8; Scan wraps at DIGITS-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  display enable; 0 forces IDLE
- ld_valid  in  1  load request
- ld_ready  out  1  staging buffer free
- hexs_in  in  32  eight 4-bit hex digits to load
- point_in  in  8  decimal points to load
- les_in  in  8  per-digit LE bits to load
- Scan  out  3  digit index to the scan mux
- Hexs  out  32  committed hex data
- point  out  8  committed points
- LES  out  8  committed LE bits
- blank  out  1  1 = all digits off
- frame_done  out  1  one-cycle pulse when Scan wraps to 0

Behaviour:
- All outputs are registered.
- Reset values:
  - Scan=0, Hexs=0, point=0, LES=0
  - blank=1, frame_done=0, ld_ready=1
  - state=IDLE, prescaler=0, blank counter=0, staging empty
- States: IDLE, SHOW, GAP.
- IDLE:
  - blank=1, Scan=0, counters held at 0.
  - en=1 → SHOW next cycle; blank drops in that same cycle.
- SHOW:
  - blank=0; prescaler counts 0..DIV_MAX.
  - At DIV_MAX: → GAP, blank=1, prescaler=0.
  - Digit visible for exactly DIV_MAX+1 cycles.
- GAP:
  - blank=1 for exactly BLANK_CYC cycles.
  - On the last GAP cycle: Scan advances (Scan==DIGITS-1 → 0, else +1), then → SHOW.
  - The new Scan value and blank=0 appear together.
  - Digit period = DIV_MAX+1+BLANK_CYC cycles.
- Frame wrap: on the cycle Scan changes DIGITS-1 → 0:
  - frame_done=1.
  - Staged data, if pending, copies to Hexs/point/LES on the same edge.
  - Staging empties, so ld_ready=1 on the following cycle.
  - DIGITS=1: every digit advance is a wrap.
- Handshake:
  - Transfer occurs when ld_valid && ld_ready at a rising edge; inputs are captured into staging and ld_ready=0 next cycle.
  - ld_valid while ld_ready=0 is ignored; the requester holds until ready.
- Simultaneous events:
  - Load on a wrap edge while staging is empty: the capture goes to staging and commits at the next wrap. No bypass.
  - Load and commit cannot coincide with staging full, because ld_ready=0.
- While en=0, or in IDLE, a pending load commits on the next cycle after capture. The display shows new data immediately on enable.
- en deasserted in SHOW or GAP: → IDLE next cycle, Scan=0, blank=1, counters cleared. A pending load commits per the IDLE rule. No frame_done pulse.
- rst mid-frame: full return to reset values; pending staging data is discarded.

Optional Feature:
- Macro: SEG_SCAN_DIMMING_EN.
- Defined:
  - Adds input port duty[3:0].
  - A free-running 4-bit PWM counter runs in SHOW only and clears on entry to SHOW.
  - In SHOW, blank = (pwm_cnt ≥ duty). duty=0 is dark; duty=15 is lit 15 of 16 cycles.
  - GAP, IDLE and all timing are unchanged.
- Undefined: no duty port; blank=0 throughout SHOW.

Decomposition:
- Package seg_scan_pkg:
  - State enum (IDLE/SHOW/GAP).
  - SCAN_W=3.
  - Reset constants for the Hexs/point/LES defaults.
- Sub-module seg_scan_prescaler:
  - Parameterised DIV_MAX/DIV_W counter with clear and enable.
  - Outputs a terminal-count pulse.
  - Reused for the GAP counter with DIV_MAX=BLANK_CYC-1.

Test Plan:
All scenarios use DIV_MAX=3, BLANK_CYC=2, DIGITS=4.
- Reset then en=1 → SHOW on the next cycle. Scan sequence 0,1,2,3,0. Each digit shows blank=0 for 4 cycles and blank=1 for 2 cycles. frame_done pulses once every 24 cycles, on the 3→0 edge.
- en=1, load hexs_in=32'h1234_5678 mid-frame at Scan=1 → ld_ready=0 next cycle. Hexs stays at its old value until the 3→0 wrap, then equals 32'h1234_5678 on that edge. ld_ready=1 on the following cycle.
- Second ld_valid while ld_ready=0 with hexs_in=32'hDEAD_BEEF → ignored. After the wrap, Hexs=32'h1234_5678. A held ld_valid is accepted on the cycle after the wrap; Hexs=32'hDEAD_BEEF at the next wrap.
- en=0 at Scan=2 in SHOW → next cycle Scan=0, blank=1, no frame_done. A load with en=0 of point_in=8'hA5 gives point=8'hA5 two cycles after the handshake edge.
- rst asserted during GAP with staging full → next cycle: all reset values, ld_ready=1, Hexs=0. No commit of the staged data.
- With SEG_SCAN_DIMMING_EN and duty=4'd2 (set DIV_MAX=15) → blank=0 for 2 of every 16 SHOW cycles. With duty=0, blank=1 throughout SHOW and Scan still advances normally.
